// File: rtl/cond_exec_unit.sv
// Execute-stage condition check, NZCV flag register and IT-block sequencer; gated writes are combinational (0 cycles).
// Flags and IT state update one cycle later. No backpressure: stall_i holds all state, and flush_i kills the stage and clears IT state.
module cond_exec_unit #(
    parameter int IT_DEPTH = 4,
    parameter bit NV_EXEC  = 1'b0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           valid_i,
    input  logic                           stall_i,
    input  logic                           flush_i,
    input  logic [3:0]                     cond_i,
    input  logic [3:0]                     alu_flags_i,
    input  logic [1:0]                     flag_w_i,
    input  logic                           pcs_i,
    input  logic                           reg_w_i,
    input  logic                           mem_w_i,
    input  logic                           no_write_i,
    input  logic                           it_start_i,
    input  logic [3:0]                     it_cond_i,
    input  logic [$clog2(IT_DEPTH+1)-1:0]  it_len_i,
    input  logic [IT_DEPTH-1:0]            it_then_i,
    output logic                           pcsrc_o,
    output logic                           reg_write_o,
    output logic                           mem_write_o,
    output logic                           cond_ex_o,
    output logic [3:0]                     flags_o,
    output logic                           it_active_o,
    output logic [$clog2(IT_DEPTH+1)-1:0]  it_remaining_o,
    output logic                           it_err_o
);

    localparam int LW = $clog2(IT_DEPTH + 1);
    localparam int SW = (IT_DEPTH > 1) ? $clog2(IT_DEPTH) : 1;

    typedef enum logic {
        IT_IDLE,
        IT_ACTIVE
    } it_state_e;

    it_state_e             state_q, state_d;
    logic [3:0]            flags_q, flags_d;
    logic [3:0]            base_q, base_d;
    logic [IT_DEPTH-1:0]   then_q, then_d;
    logic [SW-1:0]         slot_q, slot_d;
    logic [LW-1:0]         remaining_q, remaining_d;
    logic                  it_err_q, it_err_d;

    logic [3:0]            ec;
    logic                  pass;
    logic                  adv;
    logic                  len_ok;
    logic                  wen;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = ~z;
            4'h2:    cond_pass = cy;
            4'h3:    cond_pass = ~cy;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = ~n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = ~v;
            4'h8:    cond_pass = cy & ~z;
            4'h9:    cond_pass = ~cy | z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = ~z & (n == v);
            4'hD:    cond_pass = z | (n != v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = NV_EXEC;
        endcase
    endfunction

    // Condition is evaluated against last cycle's flags; no forwarding from alu_flags_i.
    always_comb begin
        ec = cond_i;
        if (state_q == IT_ACTIVE) begin
            ec = then_q[slot_q] ? base_q : {base_q[3:1], ~base_q[0]};
        end
        pass   = cond_pass(ec, flags_q);
        adv    = valid_i & ~stall_i & ~flush_i;
        len_ok = (it_len_i != '0) && (it_len_i <= LW'(IT_DEPTH));
        wen    = adv & ~reset;

        cond_ex_o   = valid_i & ~flush_i & pass;
        pcsrc_o     = wen & pcs_i & cond_ex_o;
        reg_write_o = wen & reg_w_i & cond_ex_o & ~no_write_i;
        mem_write_o = wen & mem_w_i & cond_ex_o;
    end

    always_comb begin
        state_d     = state_q;
        flags_d     = flags_q;
        base_d      = base_q;
        then_d      = then_q;
        slot_d      = slot_q;
        remaining_d = remaining_q;
        it_err_d    = 1'b0;

        if (flush_i) begin
            state_d     = IT_IDLE;
            slot_d      = '0;
            remaining_d = '0;
        end else if (adv) begin
            if (cond_ex_o && flag_w_i[1]) flags_d[3:2] = alu_flags_i[3:2];
            if (cond_ex_o && flag_w_i[0]) flags_d[1:0] = alu_flags_i[1:0];

            case (state_q)
                IT_IDLE: begin
                    if (it_start_i) begin
                        if (!len_ok) begin
                            it_err_d = 1'b1;
                        end else if (pass) begin
                            state_d     = IT_ACTIVE;
                            base_d      = it_cond_i;
                            then_d      = it_then_i;
                            slot_d      = '0;
                            remaining_d = it_len_i;
                        end
                    end
                end
                default: begin
                    // A nested IT still occupies its slot; only the start is rejected.
                    it_err_d    = it_start_i;
                    slot_d      = slot_q + SW'(1);
                    remaining_d = remaining_q - LW'(1);
                    if (remaining_q == LW'(1)) begin
                        state_d = IT_IDLE;
                        slot_d  = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IT_IDLE;
            flags_q     <= '0;
            base_q      <= '0;
            then_q      <= '0;
            slot_q      <= '0;
            remaining_q <= '0;
            it_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            flags_q     <= flags_d;
            base_q      <= base_d;
            then_q      <= then_d;
            slot_q      <= slot_d;
            remaining_q <= remaining_d;
            it_err_q    <= it_err_d;
        end
    end

    assign flags_o        = flags_q;
    assign it_active_o    = (state_q == IT_ACTIVE);
    assign it_remaining_o = remaining_q;
    assign it_err_o       = it_err_q;

endmodule

// File: tb/tb_cond_exec_unit.sv
// Scoreboard bench for cond_exec_unit: a reference model pushes expected outputs per cycle,
// which are popped and compared against the DUT before each rising edge.
module tb_cond_exec_unit;

    localparam int D  = 4;
    localparam int LW = $clog2(D + 1);
    localparam int SW = $clog2(D);

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_i, stall_i, flush_i;
    logic [3:0]    cond_i, alu_flags_i, it_cond_i;
    logic [1:0]    flag_w_i;
    logic          pcs_i, reg_w_i, mem_w_i, no_write_i, it_start_i;
    logic [LW-1:0] it_len_i;
    logic [D-1:0]  it_then_i;
    logic          pcsrc_o, reg_write_o, mem_write_o, cond_ex_o, it_active_o, it_err_o;
    logic [3:0]    flags_o;
    logic [LW-1:0] it_remaining_o;

    cond_exec_unit #(.IT_DEPTH(D), .NV_EXEC(1'b0)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
        .cond_i(cond_i), .alu_flags_i(alu_flags_i), .flag_w_i(flag_w_i), .pcs_i(pcs_i),
        .reg_w_i(reg_w_i), .mem_w_i(mem_w_i), .no_write_i(no_write_i), .it_start_i(it_start_i),
        .it_cond_i(it_cond_i), .it_len_i(it_len_i), .it_then_i(it_then_i),
        .pcsrc_o(pcsrc_o), .reg_write_o(reg_write_o), .mem_write_o(mem_write_o),
        .cond_ex_o(cond_ex_o), .flags_o(flags_o), .it_active_o(it_active_o),
        .it_remaining_o(it_remaining_o), .it_err_o(it_err_o)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0h expected %0h", phase, tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic          pcs, rw, mw, cx;
        logic [3:0]    fl;
        logic          act;
        logic [LW-1:0] rem;
        logic          err;
    } exp_t;

    exp_t sb[$];

    logic [3:0]    m_fl, m_base;
    logic [D-1:0]  m_then;
    logic          m_act, m_err;
    logic [SW-1:0] m_slot;
    logic [LW-1:0] m_rem;

    function automatic logic ccheck(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_fl = '0; m_base = '0; m_then = '0; m_act = 1'b0; m_err = 1'b0; m_slot = '0; m_rem = '0;
    endtask

    task automatic clr();
        valid_i = 0; stall_i = 0; flush_i = 0; cond_i = 4'hE; alu_flags_i = 0; flag_w_i = 0;
        pcs_i = 0; reg_w_i = 0; mem_w_i = 0; no_write_i = 0; it_start_i = 0; it_cond_i = 0;
        it_len_i = 0; it_then_i = 0;
    endtask

    // Called just after a falling edge with inputs driven; returns after the next falling edge.
    task automatic step();
        exp_t       e, g;
        logic [3:0] ec;
        logic       cx, adv, nerr;
        #1;
        ec  = m_act ? (m_then[m_slot] ? m_base : {m_base[3:1], ~m_base[0]}) : cond_i;
        cx  = valid_i && !flush_i && ccheck(ec, m_fl);
        adv = valid_i && !stall_i && !flush_i;
        e.pcs = adv && pcs_i && cx;
        e.rw  = adv && reg_w_i && cx && !no_write_i;
        e.mw  = adv && mem_w_i && cx;
        e.cx  = cx;
        e.fl  = m_fl; e.act = m_act; e.rem = m_rem; e.err = m_err;
        sb.push_back(e);
        #1;
        g = sb.pop_front();
        chk("pcsrc", 8'(pcsrc_o), 8'(g.pcs));
        chk("reg_write", 8'(reg_write_o), 8'(g.rw));
        chk("mem_write", 8'(mem_write_o), 8'(g.mw));
        chk("cond_ex", 8'(cond_ex_o), 8'(g.cx));
        chk("flags", 8'(flags_o), 8'(g.fl));
        chk("it_active", 8'(it_active_o), 8'(g.act));
        chk("it_remaining", 8'(it_remaining_o), 8'(g.rem));
        chk("it_err", 8'(it_err_o), 8'(g.err));
        nerr = 1'b0;
        if (flush_i) begin
            m_act = 1'b0; m_rem = '0; m_slot = '0;
        end else if (adv) begin
            if (!m_act) begin
                if (it_start_i) begin
                    if (it_len_i == 0 || it_len_i > D) nerr = 1'b1;
                    else if (cx) begin
                        m_act = 1'b1; m_base = it_cond_i; m_then = it_then_i;
                        m_slot = '0; m_rem = it_len_i;
                    end
                end
            end else begin
                nerr = it_start_i;
                m_slot = m_slot + 1'b1;
                m_rem  = m_rem - 1'b1;
                if (m_rem == 0) begin m_act = 1'b0; m_slot = '0; end
            end
            if (cx && flag_w_i[1]) m_fl[3:2] = alu_flags_i[3:2];
            if (cx && flag_w_i[0]) m_fl[1:0] = alu_flags_i[1:0];
        end
        m_err = nerr;
        @(negedge clk);
    endtask

    task automatic it_start(input logic [3:0] base, input logic [LW-1:0] len, input logic [D-1:0] thn);
        clr(); valid_i = 1; it_start_i = 1; it_cond_i = base; it_len_i = len; it_then_i = thn;
        step();
    endtask

    task automatic slot_rw(input logic [3:0] c);
        clr(); valid_i = 1; reg_w_i = 1; cond_i = c;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        model_reset();
        reset = 1'b1;
        valid_i = 1; reg_w_i = 1; pcs_i = 1; mem_w_i = 1;
        #12;
        phase = "reset";
        chk("rst_reg_write", 8'(reg_write_o), 8'h0);
        chk("rst_pcsrc", 8'(pcsrc_o), 8'h0);
        chk("rst_flags", 8'(flags_o), 8'h0);
        chk("rst_active", 8'(it_active_o), 8'h0);
        chk("rst_err", 8'(it_err_o), 8'h0);
        @(negedge clk);
        reset = 1'b0;

        phase = "t1";
        slot_rw(4'h0); #1 chk("eq_blocked", 8'(reg_write_o), 8'h0); step();
        slot_rw(4'hE); #1 chk("al_writes", 8'(reg_write_o), 8'h1); step();

        phase = "t2";
        slot_rw(4'hE); reg_w_i = 0; flag_w_i = 2'b10; alu_flags_i = 4'hF; step();
        chk("flags_nz", 8'(flags_o), 8'h0C);
        slot_rw(4'hE); reg_w_i = 0; flag_w_i = 2'b01; alu_flags_i = 4'hF; step();
        chk("flags_cv", 8'(flags_o), 8'h0F);

        phase = "t3";
        it_start(4'h0, 3, 4'b0101);
        slot_rw(4'hF); #1 chk("slot0_rw", 8'(reg_write_o), 8'h1); step();
        slot_rw(4'hF); #1 chk("slot1_rw", 8'(reg_write_o), 8'h0); step();
        slot_rw(4'hF); #1 chk("slot2_rw", 8'(reg_write_o), 8'h1); step();
        chk("done_active", 8'(it_active_o), 8'h0);

        phase = "t4";
        it_start(4'h2, 4, 4'b1111);
        slot_rw(4'h0); step();
        for (int i = 0; i < 2; i++) begin
            slot_rw(4'h0); stall_i = 1; #1 chk("stall_rw", 8'(reg_write_o), 8'h0); step();
            chk("stall_rem", 8'(it_remaining_o), 8'h3);
        end
        for (int i = 0; i < 3; i++) begin slot_rw(4'h0); step(); end
        chk("done_active", 8'(it_active_o), 8'h0);

        phase = "t5";
        it_start(4'hE, 4, 4'b1111);
        slot_rw(4'hE); step();
        slot_rw(4'hE); flush_i = 1; flag_w_i = 2'b11; alu_flags_i = 4'h0; step();
        chk("flush_active", 8'(it_active_o), 8'h0);
        chk("flush_flags", 8'(flags_o), 8'h0F);

        phase = "t6";
        it_start(4'hE, 2, 4'b0011);
        slot_rw(4'hE); it_start_i = 1; it_len_i = 3; step();
        slot_rw(4'hE); #1 chk("nested_err", 8'(it_err_o), 8'h1); step();
        chk("nested_err_gone", 8'(it_err_o), 8'h0);
        it_start(4'hE, 1, 4'b0001);
        chk("b2b_active", 8'(it_active_o), 8'h1);
        slot_rw(4'hE); step();
        it_start(4'hE, 0, 4'b0001);
        chk("len0_err", 8'(it_err_o), 8'h1);
        chk("len0_active", 8'(it_active_o), 8'h0);
        slot_rw(4'hF); pcs_i = 1; mem_w_i = 1;
        #1 chk("nv_writes", 8'({pcsrc_o, reg_write_o, mem_write_o}), 8'h0); step();

        phase = "t7";
        it_start(4'hE, 4, 4'b1111);
        slot_rw(4'hE); step();
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_active", 8'(it_active_o), 8'h0);
        chk("mid_rst_flags", 8'(flags_o), 8'h0);
        chk("mid_rst_rem", 8'(it_remaining_o), 8'h0);
        model_reset();
        sb.delete();
        @(negedge clk);
        reset = 1'b0;

        phase = "rand";
        for (int i = 0; i < 400; i++) begin
            clr();
            valid_i     = ($urandom_range(3) != 0);
            stall_i     = ($urandom_range(4) == 0);
            flush_i     = ($urandom_range(9) == 0);
            cond_i      = 4'($urandom_range(15));
            alu_flags_i = 4'($urandom_range(15));
            flag_w_i    = 2'($urandom_range(3));
            pcs_i       = 1'($urandom_range(1));
            reg_w_i     = 1'($urandom_range(1));
            mem_w_i     = 1'($urandom_range(1));
            no_write_i  = ($urandom_range(3) == 0);
            it_start_i  = ($urandom_range(3) == 0);
            it_cond_i   = 4'($urandom_range(14));
            it_len_i    = LW'($urandom_range(5));
            it_then_i   = D'($urandom_range(15));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
